// File: rtl/inv_shiftrows_stage.sv
// rtl/inv_shiftrows_stage.sv - AES InvShiftRows permutation feeding a 2-entry elastic buffer
// Each buffer entry holds {permuted state, last tag}; the head entry drives the outputs directly.
module inv_shiftrows_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         out_last
);

  logic [128:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  logic [127:0] w_perm;
  logic         w_push;
  logic         w_pop;

  // Row r is rotated right by r columns: output byte k takes input byte
  // 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3 for k = 0..15.
  assign w_perm = {data_in[127:120], data_in[23:16],   data_in[47:40],  data_in[71:64],
                   data_in[95:88],   data_in[119:112], data_in[15:8],   data_in[39:32],
                   data_in[63:56],   data_in[87:80],   data_in[111:104], data_in[7:0],
                   data_in[31:24],   data_in[55:48],   data_in[79:72],  data_in[103:96]};

  // Ready depends only on registered occupancy and reset, never on out_ready.
  assign in_ready  = (r_count != 2'd2) && !rst;
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign {data_out, out_last} = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_perm, in_last};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_inv_shiftrows_stage.sv
// tb/tb_inv_shiftrows_stage.sv - scoreboard bench for inv_shiftrows_stage
// Stimulus pushes reference results into a queue; a negedge monitor compares the DUT head entry.
module tb_inv_shiftrows_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;
  logic         out_last;

  int           checks = 0;
  int           failures = 0;
  logic [128:0] exp_q[$];
  logic         rst_at_edge = 1'b1;
  bit           rand_rdy = 1'b0;

  always #5 clk = ~clk;

  inv_shiftrows_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_last  (out_last)
  );

  // State viewed as a 4x4 byte matrix; row r is rotated right by r positions.
  function automatic logic [127:0] ref_inv_shift(input logic [127:0] s);
    logic [7:0]   st [4][4];
    logic [127:0] res;
    for (int k = 0; k < 16; k++) st[k % 4][k / 4] = s[127 - 8*k -: 8];
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = st[r][(c - r + 4) % 4];
    return res;
  endfunction

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) rst_at_edge <= rst;

  initial forever begin
    @(negedge clk);
    if (rst_at_edge) begin
      check("reset_out_valid", 129'(out_valid), 129'(0));
      check("reset_data_out", {data_out, out_last}, 129'(0));
    end
    if (rst) begin
      check("reset_in_ready", 129'(in_ready), 129'(0));
      exp_q.delete();
    end else begin
      check("in_ready_vs_count", 129'(in_ready), 129'(exp_q.size() != 2));
      check("out_valid_vs_count", 129'(out_valid), 129'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check("head_entry", {data_out, out_last}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
  task automatic send(input logic [127:0] d, input logic l, output int stalls);
    in_valid = 1'b1;
    data_in  = d;
    in_last  = l;
    stalls   = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (in_ready && !rst) begin
        exp_q.push_back({ref_inv_shift(d), l});
        @(posedge clk);
        #1;
        return;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout actual=not_accepted required=accepted data=%h", d);
    in_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int           st;
    int           stall_total;
    logic [127:0] a, b, c, d;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    out_ready = 1'b1;
    send(128'h000102030405060708090a0b0c0d0e0f, 1'b1, st);
    in_valid = 1'b0;
    @(negedge clk);
    check("tp_vector_valid", 129'(out_valid), 129'(1));
    check("tp_vector_data", {data_out, out_last}, {128'h000d0a0704010e0b0805020f0c090603, 1'b1});

    @(posedge clk);
    #1;
    send(128'h00050a0f04090e03080d02070c01060b, 1'b0, st);
    in_valid = 1'b0;
    @(negedge clk);
    check("round_trip", {data_out, out_last}, {128'h000102030405060708090a0b0c0d0e0f, 1'b0});

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    send(a, 1'b0, st);
    send(b, 1'b1, st);
    in_valid = 1'b1;
    data_in  = c;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("full_in_ready", 129'(in_ready), 129'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(c, 1'b0, st);

    stall_total = 0;
    for (int i = 0; i < 100; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'($urandom_range(0, 1)), st);
      stall_total += st;
    end
    in_valid = 1'b0;
    check("stream_stalls", 129'(stall_total), 129'(0));

    rand_rdy = 1'b1;
    for (int i = 0; i < 350; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'($urandom_range(0, 1)), st);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid  = 1'b0;
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_empty", 129'(exp_q.size()), 129'(0));

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1, st);
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, st);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_full", {127'(0), out_valid, in_ready}, {127'(0), 1'b1, 1'b0});
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b1;
    data_in   = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 129'(in_ready), 129'(1));
    check("post_reset_out_valid", 129'(out_valid), 129'(0));
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
